// File: rtl/tx_sample_buffer.sv
// Elastic sample FIFO between the ANC core output and the I2S DAC transmitter.
// Primes to a fill threshold with mute output, then releases one sample per frame request.
module tx_sample_buffer #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 8,
  parameter int PRIME_LVL = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        in_sample_i,
  input  logic                     in_vld_i,
  input  logic                     frame_req_i,
  input  logic                     clr_stats_i,
  output logic [DATA_W-1:0]        out_sample_o,
  output logic                     out_vld_o,
  output logic [$clog2(DEPTH):0]   fill_o,
  output logic                     running_o,
  output logic [7:0]               ovf_cnt_o,
  output logic [7:0]               udf_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam logic [FW-1:0] DEPTH_F = FW'(DEPTH);
  localparam logic [FW-1:0] PRIME_F = FW'(PRIME_LVL);

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e            state_q,     state_d;
  logic [DATA_W-1:0] outSample_q, outSample_d;
  logic              outVld_q,    outVld_d;
  logic [FW-1:0]     fill_q,      fill_d;
  logic [AW-1:0]     wrPtr_q,     wrPtr_d;
  logic [AW-1:0]     rdPtr_q,     rdPtr_d;
  logic [7:0]        ovfCnt_q,    ovfCnt_d;
  logic [7:0]        udfCnt_q,    udfCnt_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic doPop;
  logic underflow;
  logic doWrite;
  logic dropWrite;

  // A write into a full FIFO is still accepted when the same cycle pops, since
  // the slot being read frees up; writes never bypass to the output.
  always_comb begin
    doPop     = frame_req_i && (state_q == RUN) && (fill_q != '0);
    underflow = frame_req_i && (state_q == RUN) && (fill_q == '0);
    doWrite   = in_vld_i && ((fill_q != DEPTH_F) || doPop);
    dropWrite = in_vld_i && !doWrite;

    state_d     = state_q;
    outSample_d = outSample_q;
    outVld_d    = frame_req_i;
    fill_d      = fill_q;
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    ovfCnt_d    = ovfCnt_q;
    udfCnt_d    = udfCnt_q;

    case (state_q)
      PRIME: begin
        if (frame_req_i) begin
          outSample_d = '0;
        end
        if (fill_q >= PRIME_F) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (doPop) begin
          outSample_d = mem_q[rdPtr_q];
        end else if (underflow) begin
          state_d = PRIME;
        end
      end
      default: state_d = PRIME;
    endcase

    if (doWrite) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    if (doPop) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end

    case ({doWrite, doPop})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase

    if (clr_stats_i) begin
      ovfCnt_d = '0;
      udfCnt_d = '0;
    end else begin
      if (dropWrite && (ovfCnt_q != 8'hFF)) begin
        ovfCnt_d = ovfCnt_q + 8'd1;
      end
      if (underflow && (udfCnt_q != 8'hFF)) begin
        udfCnt_d = udfCnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PRIME;
      outSample_q <= '0;
      outVld_q    <= 1'b0;
      fill_q      <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      ovfCnt_q    <= '0;
      udfCnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      outSample_q <= outSample_d;
      outVld_q    <= outVld_d;
      fill_q      <= fill_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      ovfCnt_q    <= ovfCnt_d;
      udfCnt_q    <= udfCnt_d;
    end
  end

  // Storage array has no reset; occupancy is tracked entirely by fill_q.
  always_ff @(posedge clk) begin
    if (doWrite) begin
      mem_q[wrPtr_q] <= in_sample_i;
    end
  end

  assign out_sample_o = outSample_q;
  assign out_vld_o    = outVld_q;
  assign fill_o       = fill_q;
  assign running_o    = (state_q == RUN);
  assign ovf_cnt_o    = ovfCnt_q;
  assign udf_cnt_o    = udfCnt_q;

endmodule
